lane_latency_monitor: RTL and testbench

Parametrised link latency monitor for GT loopback benches and link bring-up. It generates a counting payload stream interleaved with comma IDLE words and requests comma realignment from the PHY. It then validates byte alignment of the returned stream, tracks buffer errors, and measures TX-to-RX latency (min/max) against a limit. It supersedes the fixed 16-bit checker and adds variable word width, wrap-safe latency arithmetic, a latency bound, failure classification, reset and an explicit state machine.

---
 rtl/lane_latency_monitor_if.sv | 33 +++
 rtl/lane_latency_monitor.sv | 183 ++++++++++++++++++
 tb/tb_lane_latency_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lane_latency_monitor_if.sv
// Monitor-side bus: run control, TX stream, RX stream from the PHY and status.
interface lane_latency_monitor_if #(
  parameter int unsigned g_BYTES = 2
);
  localparam int unsigned W = 8 * g_BYTES;

  logic               en_i;
  logic [W-1:0]       tx_data_o;
  logic [g_BYTES-1:0] tx_k_o;
  logic [W-1:0]       rx_data_i;
  logic [g_BYTES-1:0] rx_k_i;
  logic               rx_aligned_i;
  logic [2:0]         rx_bufstatus_i;
  logic               rx_realign_o;
  logic               pass_o;
  logic               fail_o;
  logic [1:0]         fail_code_o;
  logic [W-1:0]       latency_min_o;
  logic [W-1:0]       latency_max_o;
  logic [31:0]        cnt_ok_o;

  modport master (
    input  en_i, rx_data_i, rx_k_i, rx_aligned_i, rx_bufstatus_i,
    output tx_data_o, tx_k_o, rx_realign_o, pass_o, fail_o, fail_code_o,
           latency_min_o, latency_max_o, cnt_ok_o
  );

  modport slave (
    output en_i, rx_data_i, rx_k_i, rx_aligned_i, rx_bufstatus_i,
    input  tx_data_o, tx_k_o, rx_realign_o, pass_o, fail_o, fail_code_o,
           latency_min_o, latency_max_o, cnt_ok_o
  );
endinterface

// File: rtl/lane_latency_monitor.sv
// Loopback link monitor: counting TX stream with comma IDLEs, RX alignment
// check, buffer error tracking and wrap-safe min/max latency measurement.
module lane_latency_monitor #(
  parameter int unsigned          g_BYTES              = 2,
  parameter logic [8*g_BYTES-1:0] g_IDLE               = 16'hbc95,
  parameter int unsigned          g_IDLE_PERIOD        = 193,
  parameter int unsigned          g_BLIND_PERIOD       = 10,
  parameter int unsigned          g_NUM_SUCCESFUL_DATA = 1000,
  parameter int unsigned          g_LAT_MAX            = 64
) (
  input logic                    usrclk_i,
  input logic                    rst_i,
  lane_latency_monitor_if.master bus
);
  localparam int unsigned W  = 8 * g_BYTES;
  localparam int unsigned PW = (g_IDLE_PERIOD < 2) ? 1 : $clog2(g_IDLE_PERIOD);
  localparam int unsigned BW = (g_BLIND_PERIOD < 2) ? 1 : $clog2(g_BLIND_PERIOD);
  localparam logic [7:0]         COMMA  = g_IDLE[W-1 -: 8];
  localparam logic [g_BYTES-1:0] K_IDLE = {1'b1, {(g_BYTES-1){1'b0}}};

  typedef enum logic [2:0] {
    S_OFF, S_REALIGN, S_BLIND, S_SEEK, S_CHECK, S_PASS, S_FAIL
  } state_t;

  logic [W-1:0]       r_n;
  logic [PW-1:0]      r_p;
  logic [W-1:0]       r_tx_data;
  logic [g_BYTES-1:0] r_tx_k;

  state_t        r_state, w_state;
  logic [BW-1:0] r_blind, w_blind;
  logic          r_realign, w_realign;
  logic          r_pass, w_pass;
  logic          r_fail, w_fail;
  logic [1:0]    r_code, w_code;
  logic [W-1:0]  r_min, w_min;
  logic [W-1:0]  r_max, w_max;
  logic [31:0]   r_cnt, w_cnt;

  logic [W-1:0]  w_lat;
  logic          w_payload, w_good_idle, w_comma_lane, w_misaligned, w_bad;
  logic          w_unused_bufstatus;

  // TX generator: free-running word counter, IDLE at the start of every period
  always_ff @(posedge usrclk_i or posedge rst_i) begin : tx_gen
    if (rst_i) begin
      r_n       <= '0;
      r_p       <= '0;
      r_tx_data <= g_IDLE;
      r_tx_k    <= K_IDLE;
    end else begin
      r_n <= r_n + W'(1);
      r_p <= (r_p == PW'(g_IDLE_PERIOD - 1)) ? '0 : r_p + PW'(1);
      if (r_p == '0) begin
        r_tx_data <= g_IDLE;
        r_tx_k    <= K_IDLE;
      end else begin
        r_tx_data <= r_n;
        r_tx_k    <= '0;
      end
    end
  end

  // r_n already points one past the value currently on tx_data_o
  assign w_lat = r_n - W'(1) - bus.rx_data_i;

  assign w_payload   = (bus.rx_k_i == '0);
  assign w_good_idle = (bus.rx_k_i == K_IDLE) && (bus.rx_data_i == g_IDLE);

  always_comb begin : comma_scan
    w_comma_lane = 1'b0;
    for (int unsigned b = 0; b < g_BYTES - 1; b++) begin
      if (bus.rx_k_i[b] && (bus.rx_data_i[8*b +: 8] == COMMA)) w_comma_lane = 1'b1;
    end
  end

  assign w_misaligned       = $onehot(bus.rx_k_i) && w_comma_lane;
  assign w_bad              = !w_payload && !w_good_idle && !w_misaligned;
  assign w_unused_bufstatus = ^bus.rx_bufstatus_i[1:0];

  always_comb begin : fsm_next
    w_state   = r_state;
    w_blind   = r_blind;
    w_realign = 1'b0;
    w_pass    = 1'b0;
    w_fail    = 1'b0;
    w_code    = r_code;
    w_min     = r_min;
    w_max     = r_max;
    w_cnt     = r_cnt;
    if (!bus.en_i) begin
      w_state = S_OFF;
    end else begin
      unique case (r_state)
        S_OFF: w_state = S_REALIGN;
        S_REALIGN: begin
          if (bus.rx_aligned_i) begin
            w_state = S_BLIND;
            w_blind = '0;
          end
        end
        S_BLIND: begin
          if (!bus.rx_aligned_i)                          w_state = S_REALIGN;
          else if (r_blind == BW'(g_BLIND_PERIOD - 1))    w_state = S_SEEK;
          else                                            w_blind = r_blind + BW'(1);
        end
        S_SEEK, S_CHECK, S_PASS: begin
          if (!bus.rx_aligned_i) begin
            w_state = S_REALIGN;
          end else if (bus.rx_bufstatus_i[2]) begin
            w_state = S_FAIL;
            w_code  = 2'd2;
          end else if (w_misaligned) begin
            w_state = S_FAIL;
            w_code  = 2'd1;
          end else if (w_bad) begin
            w_state = S_FAIL;
            w_code  = 2'd0;
          end else if (r_state == S_SEEK) begin
            if (w_good_idle) w_state = S_CHECK;
          end else if (w_payload) begin
            if (w_lat > W'(g_LAT_MAX)) begin
              w_state = S_FAIL;
              w_code  = 2'd3;
            end else begin
              if (w_lat < r_min) w_min = w_lat;
              if (w_lat > r_max) w_max = w_lat;
              if (r_cnt != '1)   w_cnt = r_cnt + 32'd1;
            end
          end
          if (r_state == S_CHECK && w_state == S_CHECK &&
              r_cnt >= 32'(g_NUM_SUCCESFUL_DATA)) w_state = S_PASS;
        end
        S_FAIL:  w_state = S_FAIL;
        default: w_state = S_OFF;
      endcase
    end
    // Entering OFF or REALIGN restarts the measurement
    if (w_state == S_OFF || w_state == S_REALIGN) begin
      w_min = '1;
      w_max = '0;
      w_cnt = '0;
    end
    if (w_state == S_OFF) w_code = 2'd0;
    w_realign = (w_state == S_REALIGN);
    w_pass    = (w_state == S_PASS);
    w_fail    = (w_state == S_FAIL);
  end

  always_ff @(posedge usrclk_i or posedge rst_i) begin : fsm_reg
    if (rst_i) begin
      r_state   <= S_OFF;
      r_blind   <= '0;
      r_realign <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_code    <= 2'd0;
      r_min     <= '1;
      r_max     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_blind   <= w_blind;
      r_realign <= w_realign;
      r_pass    <= w_pass;
      r_fail    <= w_fail;
      r_code    <= w_code;
      r_min     <= w_min;
      r_max     <= w_max;
      r_cnt     <= w_cnt;
    end
  end

  assign bus.tx_data_o     = r_tx_data;
  assign bus.tx_k_o        = r_tx_k;
  assign bus.rx_realign_o  = r_realign;
  assign bus.pass_o        = r_pass;
  assign bus.fail_o        = r_fail;
  assign bus.fail_code_o   = r_code;
  assign bus.latency_min_o = r_min;
  assign bus.latency_max_o = r_max;
  assign bus.cnt_ok_o      = r_cnt;
endmodule

// File: tb/tb_lane_latency_monitor.sv
// Directed bench: three monitors looped back through delay lines.
module tb_lane_latency_monitor;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lane_latency_monitor_if #(.g_BYTES(2)) bus_a ();
  lane_latency_monitor_if #(.g_BYTES(2)) bus_b ();
  lane_latency_monitor_if #(.g_BYTES(4)) bus_c ();

  lane_latency_monitor #(.g_BYTES(2)) u_a (
    .usrclk_i(clk), .rst_i(rst), .bus(bus_a));
  lane_latency_monitor #(.g_BYTES(2), .g_LAT_MAX(5)) u_b (
    .usrclk_i(clk), .rst_i(rst), .bus(bus_b));
  lane_latency_monitor #(.g_BYTES(4), .g_IDLE(32'hbc95bc95)) u_c (
    .usrclk_i(clk), .rst_i(rst), .bus(bus_c));

  // Loopback delay lines: a D-stage shift register gives rx(k) = tx(k-D)
  logic [17:0] a_pipe [16];
  logic [17:0] b_pipe [9];
  logic [35:0] c_pipe [9];
  logic [17:0] a_sel;
  int          a_delay;
  logic        swap;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) a_pipe[i] <= '0;
      for (int i = 0; i < 9; i++) begin
        b_pipe[i] <= '0;
        c_pipe[i] <= '0;
      end
    end else begin
      for (int i = 15; i > 0; i--) a_pipe[i] <= a_pipe[i-1];
      for (int i = 8; i > 0; i--) begin
        b_pipe[i] <= b_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
      a_pipe[0] <= {bus_a.tx_k_o, bus_a.tx_data_o};
      b_pipe[0] <= {bus_b.tx_k_o, bus_b.tx_data_o};
      c_pipe[0] <= {bus_c.tx_k_o, bus_c.tx_data_o};
    end
  end

  always_comb a_sel = a_pipe[4'(a_delay - 1)];

  assign bus_a.rx_data_i = swap ? {a_sel[7:0], a_sel[15:8]} : a_sel[15:0];
  assign bus_a.rx_k_i    = swap ? {a_sel[16], a_sel[17]} : a_sel[17:16];
  assign bus_b.rx_data_i = b_pipe[8][15:0];
  assign bus_b.rx_k_i    = b_pipe[8][17:16];
  assign bus_c.rx_data_i = c_pipe[8][31:0];
  assign bus_c.rx_k_i    = c_pipe[8][35:32];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    swap = 1'b0;
    a_delay = 7;
    bus_a.en_i = 1'b0; bus_a.rx_aligned_i = 1'b0; bus_a.rx_bufstatus_i = 3'b000;
    bus_b.en_i = 1'b0; bus_b.rx_aligned_i = 1'b1; bus_b.rx_bufstatus_i = 3'b000;
    bus_c.en_i = 1'b0; bus_c.rx_aligned_i = 1'b1; bus_c.rx_bufstatus_i = 3'b000;
    tick(3);

    check("rst_tx_data", 64'(bus_a.tx_data_o), 64'h bc95);
    check("rst_tx_k",    64'(bus_a.tx_k_o), 64'h2);
    check("rst_realign", 64'(bus_a.rx_realign_o), 64'h0);
    check("rst_pass",    64'(bus_a.pass_o), 64'h0);
    check("rst_fail",    64'(bus_a.fail_o), 64'h0);
    check("rst_code",    64'(bus_a.fail_code_o), 64'h0);
    check("rst_min",     64'(bus_a.latency_min_o), 64'hffff);
    check("rst_max",     64'(bus_a.latency_max_o), 64'h0);
    check("rst_cnt",     64'(bus_a.cnt_ok_o), 64'h0);
    check("rst_min_c",   64'(bus_c.latency_min_o), 64'hffff_ffff);

    rst = 1'b0;
    tick(1);
    check("first_word_idle", 64'(bus_a.tx_data_o), 64'hbc95);
    check("first_word_k",    64'(bus_a.tx_k_o), 64'h2);
    tick(1);
    check("payload_1",   64'(bus_a.tx_data_o), 64'h1);
    check("payload_1_k", 64'(bus_a.tx_k_o), 64'h0);
    tick(192);
    check("period_idle",   64'(bus_a.tx_data_o), 64'hbc95);
    check("period_idle_k", 64'(bus_a.tx_k_o), 64'h2);
    tick(1);
    check("payload_194", 64'(bus_a.tx_data_o), 64'd194);

    // Realign request held until the PHY reports alignment
    bus_a.en_i = 1'b1; bus_b.en_i = 1'b1; bus_c.en_i = 1'b1;
    tick(1);
    check("realign_rise", 64'(bus_a.rx_realign_o), 64'h1);
    tick(3);
    check("realign_hold", 64'(bus_a.rx_realign_o), 64'h1);
    bus_a.rx_aligned_i = 1'b1;
    tick(1);
    check("realign_drop", 64'(bus_a.rx_realign_o), 64'h0);

    for (int i = 0; i < 3000 && bus_a.pass_o !== 1'b1; i++) tick(1);
    check("a_pass",     64'(bus_a.pass_o), 64'h1);
    check("a_fail",     64'(bus_a.fail_o), 64'h0);
    check("a_min",      64'(bus_a.latency_min_o), 64'd7);
    check("a_max",      64'(bus_a.latency_max_o), 64'd7);
    check("a_cnt_ge_n", 64'(bus_a.cnt_ok_o >= 32'd1000), 64'h1);

    for (int i = 0; i < 3000 && bus_c.pass_o !== 1'b1; i++) tick(1);
    check("c_pass", 64'(bus_c.pass_o), 64'h1);
    check("c_fail", 64'(bus_c.fail_o), 64'h0);
    check("c_min",  64'(bus_c.latency_min_o), 64'd9);
    check("c_max",  64'(bus_c.latency_max_o), 64'd9);

    check("b_fail", 64'(bus_b.fail_o), 64'h1);
    check("b_code", 64'(bus_b.fail_code_o), 64'd3);
    check("b_pass", 64'(bus_b.pass_o), 64'h0);
    check("b_min",  64'(bus_b.latency_min_o), 64'hffff);

    // Alignment loss after 500 words restarts the measurement without failing
    bus_a.en_i = 1'b0;
    tick(1);
    check("off_pass", 64'(bus_a.pass_o), 64'h0);
    check("off_cnt",  64'(bus_a.cnt_ok_o), 64'h0);
    check("off_min",  64'(bus_a.latency_min_o), 64'hffff);
    bus_a.en_i = 1'b1;
    for (int i = 0; i < 2000 && bus_a.cnt_ok_o != 32'd500; i++) tick(1);
    check("cnt_500", 64'(bus_a.cnt_ok_o), 64'd500);
    bus_a.rx_aligned_i = 1'b0;
    tick(1);
    check("drop_realign", 64'(bus_a.rx_realign_o), 64'h1);
    check("drop_cnt",     64'(bus_a.cnt_ok_o), 64'h0);
    check("drop_max",     64'(bus_a.latency_max_o), 64'h0);
    check("drop_fail",    64'(bus_a.fail_o), 64'h0);
    tick(4);
    bus_a.rx_aligned_i = 1'b1;
    for (int i = 0; i < 3000 && bus_a.pass_o !== 1'b1; i++) tick(1);
    check("relock_pass", 64'(bus_a.pass_o), 64'h1);
    check("relock_fail", 64'(bus_a.fail_o), 64'h0);
    check("relock_min",  64'(bus_a.latency_min_o), 64'd7);

    // One-cycle buffer error while checking
    bus_a.en_i = 1'b0;
    tick(1);
    bus_a.en_i = 1'b1;
    for (int i = 0; i < 1000 && bus_a.cnt_ok_o < 32'd20; i++) tick(1);
    check("buf_pre_cnt", 64'(bus_a.cnt_ok_o >= 32'd20), 64'h1);
    bus_a.rx_bufstatus_i = 3'b101;
    tick(1);
    bus_a.rx_bufstatus_i = 3'b000;
    check("buf_fail", 64'(bus_a.fail_o), 64'h1);
    check("buf_code", 64'(bus_a.fail_code_o), 64'd2);
    check("buf_pass", 64'(bus_a.pass_o), 64'h0);
    tick(20);
    check("buf_fail_hold", 64'(bus_a.fail_o), 64'h1);
    check("buf_code_hold", 64'(bus_a.fail_code_o), 64'd2);
    bus_a.en_i = 1'b0;
    tick(1);
    check("buf_clear_fail", 64'(bus_a.fail_o), 64'h0);
    check("buf_clear_code", 64'(bus_a.fail_code_o), 64'h0);

    // Byte-swapped loopback shows the comma on the low lane
    swap = 1'b1;
    bus_a.en_i = 1'b1;
    for (int i = 0; i < 1000 && bus_a.fail_o !== 1'b1; i++) tick(1);
    check("swap_fail", 64'(bus_a.fail_o), 64'h1);
    check("swap_code", 64'(bus_a.fail_code_o), 64'd1);
    check("swap_pass", 64'(bus_a.pass_o), 64'h0);

    // Long run across the 16-bit counter wrap with delay 3
    bus_a.en_i = 1'b0;
    swap = 1'b0;
    a_delay = 3;
    tick(1);
    bus_a.en_i = 1'b1;
    tick(70000);
    check("wrap_fail", 64'(bus_a.fail_o), 64'h0);
    check("wrap_pass", 64'(bus_a.pass_o), 64'h1);
    check("wrap_min",  64'(bus_a.latency_min_o), 64'd3);
    check("wrap_max",  64'(bus_a.latency_max_o), 64'd3);
    check("wrap_cnt",  64'(bus_a.cnt_ok_o > 32'd65536), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
